// File: rtl/wb_pkg.sv
// Shared types and constants for the register-file writeback front end.
package wb_pkg;
    localparam int XLEN_DEFAULT = 32;
    localparam int REG_ADDR_W   = 5;
    localparam int NUM_REGS     = 1 << REG_ADDR_W;

    typedef struct packed {
        logic [REG_ADDR_W-1:0]   addr;
        logic [XLEN_DEFAULT-1:0] data;
    } wb_entry_t;

    // One-hot register select. x0 is masked because it is never tracked as busy.
    function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_ADDR_W-1:0] a);
        logic [NUM_REGS-1:0] v;
        v    = '0;
        v[a] = 1'b1;
        v[0] = 1'b0;
        return v;
    endfunction
endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO holding long-latency writeback entries.
// Pointers wrap modulo DEPTH; full/empty come from the registered count.
module wb_fifo
    import wb_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  wb_entry_t        i_data,
    input  logic             i_pop,
    output wb_entry_t        o_data,
    output logic             o_full,
    output logic             o_empty,
    output logic [CNT_W-1:0] o_count
);

    wb_entry_t        r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_data    = r_mem[r_rd_ptr];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    // Storage carries no reset; stale entries are unreachable once pointers reset.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_do_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (!w_do_push && w_do_pop) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/regfile_writeback.sv
// Merges pipeline and long-latency results onto the single register-file write port.
// Define REGFILE_WB_FWD_EN to add write-port forwarding and early busy clear.
module regfile_writeback
    import wb_pkg::*;
#(
    parameter int XLEN         = XLEN_DEFAULT,
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pipe_valid,
    input  logic [REG_ADDR_W-1:0] pipe_rd_addr,
    input  logic [XLEN-1:0]       pipe_rd,
    input  logic                  lu_valid,
    output logic                  lu_ready,
    input  logic [REG_ADDR_W-1:0] lu_rd_addr,
    input  logic [XLEN-1:0]       lu_rd,
    input  logic                  issue_valid,
    input  logic [REG_ADDR_W-1:0] issue_rd_addr,
    input  logic [REG_ADDR_W-1:0] rs1_addr,
    input  logic [REG_ADDR_W-1:0] rs2_addr,
    output logic                  rs1_busy,
    output logic                  rs2_busy,
    output logic                  pipe_stall,
`ifdef REGFILE_WB_FWD_EN
    output logic                  rs1_fwd_valid,
    output logic                  rs2_fwd_valid,
    output logic [XLEN-1:0]       rs1_fwd,
    output logic [XLEN-1:0]       rs2_fwd,
`endif
    output logic [REG_ADDR_W-1:0] rd_addr,
    output logic [XLEN-1:0]       rd,
    output logic                  write
);

    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int WAIT_W = $clog2(STARVE_LIMIT + 1);

    logic                  w_full;
    logic                  w_empty;
    logic [CNT_W-1:0]      w_count;
    wb_entry_t             w_push_entry;
    wb_entry_t             w_head;
    logic                  w_pipe_sel;
    logic                  w_pop;
    logic                  w_push;
    logic [WAIT_W-1:0]     r_wait;
    logic [WAIT_W-1:0]     w_wait_next;
    logic                  r_stall;
    logic                  w_stall_next;
    logic                  r_write;
    logic [REG_ADDR_W-1:0] r_rd_addr;
    logic [XLEN-1:0]       r_rd;
    logic [NUM_REGS-1:0]   r_busy;
    logic [NUM_REGS-1:0]   w_set_vec;
    logic [NUM_REGS-1:0]   w_clear_vec;

    // A pipeline write to x0 is not a request, letting the FIFO drain that cycle.
    assign w_pipe_sel   = !r_stall && pipe_valid && (pipe_rd_addr != '0);
    assign w_pop        = !w_pipe_sel && !w_empty;
    assign lu_ready     = !rst && !w_full;
    assign w_push       = lu_valid && lu_ready;
    assign w_push_entry = '{addr: lu_rd_addr, data: XLEN_DEFAULT'(lu_rd)};

    wb_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (w_push_entry),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    always_comb begin
        w_wait_next  = r_wait;
        w_stall_next = r_stall;
        if (w_pop || w_empty) begin
            w_wait_next = '0;
        end else if (r_wait != WAIT_W'(STARVE_LIMIT)) begin
            w_wait_next = r_wait + WAIT_W'(1);
        end
        if (w_pop) begin
            w_stall_next = 1'b0;
        end else if (w_wait_next == WAIT_W'(STARVE_LIMIT)) begin
            w_stall_next = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wait  <= '0;
            r_stall <= 1'b0;
        end else begin
            r_wait  <= w_wait_next;
            r_stall <= w_stall_next;
        end
    end

    // Popped x0 entries are consumed but never reach the register file.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_write   <= 1'b0;
            r_rd_addr <= '0;
            r_rd      <= '0;
        end else if (w_pipe_sel) begin
            r_write   <= 1'b1;
            r_rd_addr <= pipe_rd_addr;
            r_rd      <= pipe_rd;
        end else if (w_pop) begin
            r_write   <= (w_head.addr != '0);
            r_rd_addr <= w_head.addr;
            r_rd      <= XLEN'(w_head.data);
        end else begin
            r_write   <= 1'b0;
        end
    end

    assign w_set_vec = issue_valid ? reg_onehot(issue_rd_addr) : '0;

`ifdef REGFILE_WB_FWD_EN
    assign w_clear_vec   = w_pop ? reg_onehot(w_head.addr) : '0;
    assign rs1_fwd_valid = r_write && (r_rd_addr == rs1_addr) && (rs1_addr != '0);
    assign rs2_fwd_valid = r_write && (r_rd_addr == rs2_addr) && (rs2_addr != '0);
    assign rs1_fwd       = r_rd;
    assign rs2_fwd       = r_rd;
`else
    logic r_lu_commit;

    // Remembers that the word on the write port came from the FIFO, so its bit clears after the write.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lu_commit <= 1'b0;
        end else begin
            r_lu_commit <= !w_pipe_sel && w_pop && (w_head.addr != '0);
        end
    end

    assign w_clear_vec = r_lu_commit ? reg_onehot(r_rd_addr) : '0;
`endif

    // Clear before set so a same-cycle reissue keeps the register busy.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= '0;
        end else begin
            r_busy <= (r_busy & ~w_clear_vec) | w_set_vec;
        end
    end

    assign rs1_busy   = r_busy[rs1_addr];
    assign rs2_busy   = r_busy[rs2_addr];
    assign pipe_stall = r_stall;
    assign write      = r_write;
    assign rd_addr    = r_rd_addr;
    assign rd         = r_rd;

    a_issue_not_busy: assert property (@(posedge clk) disable iff (rst)
        (issue_valid && issue_rd_addr != '0) |-> (!r_busy[issue_rd_addr] || w_clear_vec[issue_rd_addr]));

    a_pipe_not_busy: assert property (@(posedge clk) disable iff (rst)
        w_pipe_sel |-> !r_busy[pipe_rd_addr]);

    a_count_in_range: assert property (@(posedge clk) disable iff (rst)
        w_count <= CNT_W'(FIFO_DEPTH));

endmodule

// File: tb/tb_regfile_writeback.sv
// Directed, table-driven bench for regfile_writeback, with hand sequences for
// contention/starvation, same-cycle issue/commit and reset mid-operation.
module tb_regfile_writeback;

    localparam int XLEN = 32;
`ifdef REGFILE_WB_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic            pipe_valid;
    logic [4:0]      pipe_rd_addr;
    logic [XLEN-1:0] pipe_rd;
    logic            lu_valid;
    logic            lu_ready;
    logic [4:0]      lu_rd_addr;
    logic [XLEN-1:0] lu_rd;
    logic            issue_valid;
    logic [4:0]      issue_rd_addr;
    logic [4:0]      rs1_addr;
    logic [4:0]      rs2_addr;
    logic            rs1_busy;
    logic            rs2_busy;
    logic            pipe_stall;
`ifdef REGFILE_WB_FWD_EN
    logic            rs1_fwd_valid;
    logic            rs2_fwd_valid;
    logic [XLEN-1:0] rs1_fwd;
    logic [XLEN-1:0] rs2_fwd;
`endif
    logic [4:0]      rd_addr;
    logic [XLEN-1:0] rd;
    logic            write;

    int passCount  = 0;
    int checkCount = 0;

    always #5 clk = ~clk;

    regfile_writeback #(
        .XLEN         (XLEN),
        .FIFO_DEPTH   (2),
        .STARVE_LIMIT (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .pipe_valid    (pipe_valid),
        .pipe_rd_addr  (pipe_rd_addr),
        .pipe_rd       (pipe_rd),
        .lu_valid      (lu_valid),
        .lu_ready      (lu_ready),
        .lu_rd_addr    (lu_rd_addr),
        .lu_rd         (lu_rd),
        .issue_valid   (issue_valid),
        .issue_rd_addr (issue_rd_addr),
        .rs1_addr      (rs1_addr),
        .rs2_addr      (rs2_addr),
        .rs1_busy      (rs1_busy),
        .rs2_busy      (rs2_busy),
        .pipe_stall    (pipe_stall),
`ifdef REGFILE_WB_FWD_EN
        .rs1_fwd_valid (rs1_fwd_valid),
        .rs2_fwd_valid (rs2_fwd_valid),
        .rs1_fwd       (rs1_fwd),
        .rs2_fwd       (rs2_fwd),
`endif
        .rd_addr       (rd_addr),
        .rd            (rd),
        .write         (write)
    );

    typedef struct {
        logic        pv;
        logic [4:0]  pa;
        logic [31:0] pd;
        logic        lv;
        logic [4:0]  la;
        logic [31:0] ld;
        logic        iv;
        logic [4:0]  ia;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic        eW;
        logic [4:0]  eA;
        logic [31:0] eD;
        logic        eB1;
        logic        eB2;
        logic        eRdy;
        logic        eStl;
        logic        eF2v;
        logic [31:0] eF2;
    } vec_t;

    vec_t tbl [16];

    // Expected write-port behaviour while the pipeline floods the port and three lu results arrive.
    logic        cW   [10] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 0};
    logic [4:0]  cA   [10] = '{1, 1, 1, 1, 1, 10, 1, 11, 12, 0};
    logic [31:0] cD   [10] = '{32'h100, 32'h101, 32'h102, 32'h103, 32'h104,
                               32'hA0, 32'h106, 32'hB0, 32'hC0, 32'h0};
    logic        cStl [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 0};
    logic        cRdy [10] = '{1, 0, 0, 0, 0, 1, 0, 1, 1, 1};
    logic [4:0]  luA  [3]  = '{5'd10, 5'd11, 5'd12};
    logic [31:0] luD  [3]  = '{32'hA0, 32'hB0, 32'hC0};

    function automatic vec_t mk(
        input logic pv, input logic [4:0] pa, input logic [31:0] pd,
        input logic lv, input logic [4:0] la, input logic [31:0] ld,
        input logic iv, input logic [4:0] ia,
        input logic [4:0] r1, input logic [4:0] r2,
        input logic eW, input logic [4:0] eA, input logic [31:0] eD,
        input logic eB1, input logic eB2, input logic eRdy, input logic eStl,
        input logic eF2v, input logic [31:0] eF2);
        vec_t v;
        v.pv = pv; v.pa = pa; v.pd = pd;
        v.lv = lv; v.la = la; v.ld = ld;
        v.iv = iv; v.ia = ia; v.r1 = r1; v.r2 = r2;
        v.eW = eW; v.eA = eA; v.eD = eD;
        v.eB1 = eB1; v.eB2 = eB2; v.eRdy = eRdy; v.eStl = eStl;
        v.eF2v = eF2v; v.eF2 = eF2;
        return v;
    endfunction

    task automatic applyStimulus(input vec_t v);
        pipe_valid    = v.pv;
        pipe_rd_addr  = v.pa;
        pipe_rd       = v.pd;
        lu_valid      = v.lv;
        lu_rd_addr    = v.la;
        lu_rd         = v.ld;
        issue_valid   = v.iv;
        issue_rd_addr = v.ia;
        rs1_addr      = v.r1;
        rs2_addr      = v.r2;
    endtask

    task automatic idle(input logic [4:0] r1, input logic [4:0] r2);
        applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 0, r1, r2, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act === exp) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        idle(5'd7, 5'd9);

        // Reset held for two cycles.
        step();
        checkOutput("rst write c1", 32'(write), 32'd0);
        checkOutput("rst lu_ready c1", 32'(lu_ready), 32'd0);
        step();
        checkOutput("rst write", 32'(write), 32'd0);
        checkOutput("rst rd_addr", 32'(rd_addr), 32'd0);
        checkOutput("rst rd", rd, 32'd0);
        checkOutput("rst rs1_busy", 32'(rs1_busy), 32'd0);
        checkOutput("rst rs2_busy", 32'(rs2_busy), 32'd0);
        checkOutput("rst pipe_stall", 32'(pipe_stall), 32'd0);
        checkOutput("rst lu_ready", 32'(lu_ready), 32'd0);
        rst = 1'b0;
        #1;
        checkOutput("post-rst lu_ready", 32'(lu_ready), 32'd1);
        step();

        //              pv pa  pd            lv la  ld        iv ia  r1  r2  eW eA  eD            eB1     eB2     Rdy Stl F2v F2
        tbl[0]  = mk(1, 5,  32'hDEADBEEF, 0, 0,  0,        0, 0,  0,  0,  1, 5,  32'hDEADBEEF, 0,      0,      1,  0,  0,  0);
        tbl[1]  = mk(1, 0,  32'h55,       0, 0,  0,        0, 0,  0,  0,  0, 0,  0,            0,      0,      1,  0,  0,  0);
        tbl[2]  = mk(0, 0,  0,            0, 0,  0,        1, 7,  7,  0,  0, 0,  0,            1,      0,      1,  0,  0,  0);
        tbl[3]  = mk(0, 0,  0,            1, 7,  32'h1234, 0, 0,  7,  0,  0, 0,  0,            1,      0,      1,  0,  0,  0);
        tbl[4]  = mk(0, 0,  0,            0, 0,  0,        0, 0,  7,  0,  1, 7,  32'h1234,     !FWD,   0,      1,  0,  0,  0);
        tbl[5]  = mk(0, 0,  0,            0, 0,  0,        0, 0,  7,  0,  0, 0,  0,            0,      0,      1,  0,  0,  0);
        tbl[6]  = mk(1, 3,  32'hAA,       0, 0,  0,        0, 0,  0,  3,  1, 3,  32'hAA,       0,      0,      1,  0,  1,  32'hAA);
        tbl[7]  = mk(1, 3,  32'hBB,       0, 0,  0,        0, 0,  0,  0,  1, 3,  32'hBB,       0,      0,      1,  0,  0,  0);
        tbl[8]  = mk(0, 0,  0,            1, 0,  32'h99,   0, 0,  0,  0,  0, 0,  0,            0,      0,      1,  0,  0,  0);
        tbl[9]  = mk(0, 0,  0,            0, 0,  0,        0, 0,  0,  0,  0, 0,  0,            0,      0,      1,  0,  0,  0);
        tbl[10] = mk(0, 0,  0,            1, 20, 32'h2020, 1, 20, 20, 20, 0, 0,  0,            1,      1,      1,  0,  0,  0);
        tbl[11] = mk(0, 0,  0,            0, 0,  0,        0, 0,  20, 20, 1, 20, 32'h2020,     !FWD,   !FWD,   1,  0,  0,  0);
        tbl[12] = mk(0, 0,  0,            0, 0,  0,        0, 0,  20, 20, 0, 0,  0,            0,      0,      1,  0,  0,  0);
        tbl[13] = mk(0, 0,  0,            1, 21, 32'h21,   0, 0,  0,  0,  0, 0,  0,            0,      0,      1,  0,  0,  0);
        tbl[14] = mk(1, 22, 32'h22,       0, 0,  0,        0, 0,  0,  0,  1, 22, 32'h22,       0,      0,      1,  0,  0,  0);
        tbl[15] = mk(0, 0,  0,            0, 0,  0,        0, 0,  0,  0,  1, 21, 32'h21,       0,      0,      1,  0,  0,  0);

        for (int i = 0; i < 16; i++) begin
            applyStimulus(tbl[i]);
            step();
            checkOutput($sformatf("row%0d write", i), 32'(write), 32'(tbl[i].eW));
            if (tbl[i].eW) begin
                checkOutput($sformatf("row%0d rd_addr", i), 32'(rd_addr), 32'(tbl[i].eA));
                checkOutput($sformatf("row%0d rd", i), rd, tbl[i].eD);
            end
            checkOutput($sformatf("row%0d rs1_busy", i), 32'(rs1_busy), 32'(tbl[i].eB1));
            checkOutput($sformatf("row%0d rs2_busy", i), 32'(rs2_busy), 32'(tbl[i].eB2));
            checkOutput($sformatf("row%0d lu_ready", i), 32'(lu_ready), 32'(tbl[i].eRdy));
            checkOutput($sformatf("row%0d pipe_stall", i), 32'(pipe_stall), 32'(tbl[i].eStl));
`ifdef REGFILE_WB_FWD_EN
            checkOutput($sformatf("row%0d rs2_fwd_valid", i), 32'(rs2_fwd_valid), 32'(tbl[i].eF2v));
            if (tbl[i].eF2v) begin
                checkOutput($sformatf("row%0d rs2_fwd", i), rs2_fwd, tbl[i].eF2);
            end
`endif
        end

        // Contention: pipeline busy every cycle until c6, three lu results offered back to back.
        begin
            int luIdx;
            logic accepted;
            luIdx = 0;
            for (int c = 0; c < 10; c++) begin
                idle(0, 0);
                pipe_valid   = (c <= 6);
                pipe_rd_addr = 5'd1;
                pipe_rd      = 32'h100 + 32'(c);
                lu_valid     = (luIdx < 3);
                lu_rd_addr   = (luIdx < 3) ? luA[luIdx] : 5'd0;
                lu_rd        = (luIdx < 3) ? luD[luIdx] : 32'd0;
                accepted     = lu_valid && lu_ready;
                step();
                if (accepted) luIdx++;
                checkOutput($sformatf("cont c%0d write", c), 32'(write), 32'(cW[c]));
                if (cW[c]) begin
                    checkOutput($sformatf("cont c%0d rd_addr", c), 32'(rd_addr), 32'(cA[c]));
                    checkOutput($sformatf("cont c%0d rd", c), rd, cD[c]);
                end
                checkOutput($sformatf("cont c%0d pipe_stall", c), 32'(pipe_stall), 32'(cStl[c]));
                checkOutput($sformatf("cont c%0d lu_ready", c), 32'(lu_ready), 32'(cRdy[c]));
            end
            checkOutput("cont accepted count", 32'(luIdx), 32'd3);
        end

        // Same-cycle issue and commit on x9: the set must win.
        idle(5'd9, 5'd0);
        issue_valid = 1'b1; issue_rd_addr = 5'd9;
        step();
        checkOutput("x9 busy after issue", 32'(rs1_busy), 32'd1);
        idle(5'd9, 5'd0);
        lu_valid = 1'b1; lu_rd_addr = 5'd9; lu_rd = 32'h9999;
        step();
        idle(5'd9, 5'd0);
        if (FWD) begin
            issue_valid = 1'b1; issue_rd_addr = 5'd9;
        end
        step();
        checkOutput("x9 write", 32'(write), 32'd1);
        checkOutput("x9 rd_addr", 32'(rd_addr), 32'd9);
        checkOutput("x9 rd", rd, 32'h9999);
        checkOutput("x9 busy at write", 32'(rs1_busy), 32'd1);
        idle(5'd9, 5'd0);
        if (!FWD) begin
            issue_valid = 1'b1; issue_rd_addr = 5'd9;
        end
        step();
        checkOutput("x9 busy after commit", 32'(rs1_busy), 32'd1);
        idle(5'd9, 5'd0);
        step();
        checkOutput("x9 busy held", 32'(rs1_busy), 32'd1);

        // Reset mid-operation with two buffered results and x14 busy.
        idle(5'd14, 5'd9);
        pipe_valid = 1'b1; pipe_rd_addr = 5'd1; pipe_rd = 32'h1;
        lu_valid = 1'b1; lu_rd_addr = 5'd13; lu_rd = 32'h1313;
        issue_valid = 1'b1; issue_rd_addr = 5'd14;
        step();
        idle(5'd14, 5'd9);
        pipe_valid = 1'b1; pipe_rd_addr = 5'd1; pipe_rd = 32'h2;
        lu_valid = 1'b1; lu_rd_addr = 5'd15; lu_rd = 32'h1515;
        step();
        checkOutput("midrst full", 32'(lu_ready), 32'd0);
        checkOutput("midrst x14 busy", 32'(rs1_busy), 32'd1);
        idle(5'd14, 5'd9);
        rst = 1'b1;
        step();
        checkOutput("midrst write", 32'(write), 32'd0);
        checkOutput("midrst lu_ready in rst", 32'(lu_ready), 32'd0);
        rst = 1'b0;
        #1;
        checkOutput("midrst x14 cleared", 32'(rs1_busy), 32'd0);
        checkOutput("midrst x9 cleared", 32'(rs2_busy), 32'd0);
        checkOutput("midrst lu_ready", 32'(lu_ready), 32'd1);
        step();
        checkOutput("midrst no drain c1", 32'(write), 32'd0);
        step();
        checkOutput("midrst no drain c2", 32'(write), 32'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
